// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx : start / LSB-first data / optional parity / stop serialiser |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int              BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] last_q, last_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      slot_end;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    slot_end  = (cnt_q == last_q);

    if (state_q != S_IDLE) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (Data_Valid) begin
          state_d   = S_START;
          shreg_d   = P_DATA;
          par_en_d  = parity_enable;
          par_bit_d = (^P_DATA) ^ parity_type;
          // Storing P-1 lets Prescale=0 wrap to 2^W-1, i.e. a full 2^W-cycle slot.
          last_d    = Prescale - 1'b1;
          cnt_d     = '0;
          bit_d     = '0;
        end
      end
      S_START: begin
        if (slot_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (slot_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (slot_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          bit_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the flops present them in step with it.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx : self-checking bench for uart_tx                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       parity_enable;
  logic       parity_type;
  logic [4:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .P_DATA        (P_DATA),
    .Data_Valid    (Data_Valid),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .Prescale      (Prescale),
    .TX_OUT        (TX_OUT),
    .Busy          (Busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  logic got_q[$];

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [4:0] pr;
    int         len;
    logic       par;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: list of bit values, each stretched to P samples.
  task automatic build_model(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] pr);
    int p;
    bit bits[$];
    p = (pr == 5'd0) ? 32 : int'(pr);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((($countones(d) % 2) == 1) ^ pt);
    bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[k]) repeat (p) exp_q.push_back(bits[k]);
  endtask

  task automatic request(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] pr);
    @(negedge CLK);
    P_DATA = d; parity_enable = pe; parity_type = pt; Prescale = pr;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  // Called at the negedge of the first frame cycle; returns at the first idle negedge.
  task automatic capture(input bit disturb);
    int n;
    n = 0;
    got_q.delete();
    while (Busy === 1'b1 && n < 5000) begin
      got_q.push_back(TX_OUT);
      if (disturb && n == 20) begin
        Data_Valid = 1'b1; P_DATA = 8'h3C; Prescale = 5'd3; parity_type = ~parity_type;
      end
      if (disturb && n == 21) Data_Valid = 1'b0;
      n++;
      @(negedge CLK);
    end
    check("frame_bounded", (n < 5000), 1);
    check("idle_tx", TX_OUT, 1'b1);
    check("idle_busy", Busy, 1'b0);
  endtask

  task automatic compare_frame(input string name);
    int mism;
    mism = 0;
    check({name, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[k]) begin
      if (k < got_q.size()) begin
        if (got_q[k] !== logic'(exp_q[k])) mism++;
      end
    end
    check({name, "_wave_mismatches"}, mism, 0);
  endtask

  initial begin
    tbl[0] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, pr: 5'd8, len: 88,  par: 1'b0};
    tbl[1] = '{d: 8'h01, pe: 1'b1, pt: 1'b1, pr: 5'd8, len: 88,  par: 1'b0};
    tbl[2] = '{d: 8'h01, pe: 1'b0, pt: 1'b0, pr: 5'd8, len: 80,  par: 1'b0};
    tbl[3] = '{d: 8'h01, pe: 1'b0, pt: 1'b0, pr: 5'd0, len: 320, par: 1'b0};

    // Reset with a pending request
    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'hFF;
    parity_enable = 1'b0; parity_type = 1'b0; Prescale = 5'd8;
    repeat (2) begin
      @(negedge CLK);
      check("reset_tx", TX_OUT, 1'b1);
      check("reset_busy", Busy, 1'b0);
    end
    RST = 1'b0; Data_Valid = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      check("post_reset_tx", TX_OUT, 1'b1);
      check("post_reset_busy", Busy, 1'b0);
    end

    // Directed table: even/odd/no parity and Prescale=0
    for (int i = 0; i < 4; i++) begin
      int p;
      p = (tbl[i].pr == 5'd0) ? 32 : int'(tbl[i].pr);
      request(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].pr);
      build_model(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].pr);
      capture(1'b0);
      check($sformatf("tbl%0d_busy_len", i), got_q.size(), tbl[i].len);
      if (tbl[i].pe && got_q.size() > 9 * p + p / 2)
        check($sformatf("tbl%0d_parity", i), got_q[9 * p + p / 2], tbl[i].par);
      compare_frame($sformatf("tbl%0d", i));
    end

    // Mid-frame request and input changes are ignored
    request(8'hA5, 1'b1, 1'b0, 5'd8);
    build_model(8'hA5, 1'b1, 1'b0, 5'd8);
    capture(1'b1);
    compare_frame("disturbed");
    repeat (3) begin
      @(negedge CLK);
      check("no_queue_busy", Busy, 1'b0);
      check("no_queue_tx", TX_OUT, 1'b1);
    end
    request(8'h3C, 1'b1, 1'b0, 5'd8);
    build_model(8'h3C, 1'b1, 1'b0, 5'd8);
    capture(1'b0);
    compare_frame("after_busy_3c");

    // Reset during data bit 3 (P=4: slot 4 spans frame cycles 16..19)
    request(8'hA5, 1'b0, 1'b0, 5'd4);
    repeat (17) @(negedge CLK);
    check("pre_abort_busy", Busy, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_tx", TX_OUT, 1'b1);
    check("abort_busy", Busy, 1'b0);
    request(8'h5A, 1'b0, 1'b0, 5'd4);
    build_model(8'h5A, 1'b0, 1'b0, 5'd4);
    capture(1'b0);
    compare_frame("after_abort_5a");

    // Back-to-back with Data_Valid held high
    @(negedge CLK);
    P_DATA = 8'h00; parity_enable = 1'b1; parity_type = 1'b0; Prescale = 5'd2;
    Data_Valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hFF;
    build_model(8'h00, 1'b1, 1'b0, 5'd2);
    capture(1'b0);
    compare_frame("b2b_00");
    @(negedge CLK);
    Data_Valid = 1'b0;
    build_model(8'hFF, 1'b1, 1'b0, 5'd2);
    capture(1'b0);
    compare_frame("b2b_ff");

    // Randomized frames against the reference model
    for (int r = 0; r < 10; r++) begin
      logic [7:0] d;
      logic       pe, pt;
      logic [4:0] pr;
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      pr = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      request(d, pe, pt, pr);
      build_model(d, pe, pt, pr);
      capture(1'b0);
      compare_frame($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
